// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Merges the instruction-fetch port and the data-memory port onto one
// single-port unified memory.  Each granted request becomes exactly one
// serialized memory transaction.  Read data returns only to the requesting
// side in a dedicated register, and each side sees a stall while it waits.
//
// Ports
//   clk, rst_n                     rising-edge clock, async active-low reset
//   if_req/if_addr                 fetch request (level) and byte address
//   if_done/if_rdata/if_stall      fetch completion pulse, instruction, stall
//   dm_req/dm_we/dm_wstrb/
//   dm_addr/dm_wdata               data request (level), store/load, strobes,
//                                  byte address, store data
//   dm_done/dm_rdata/dm_stall      data completion pulse, load data, stall
//   err                            one-cycle pulse when an access times out
//   mem_req/mem_we/mem_wstrb/
//   mem_addr/mem_wdata             memory access strobe and latched fields
//   mem_rdata/mem_ready            memory read data and completion
// -----------------------------------------------------------------------------

// Invariant checks on the arbiter outputs; no logic, simulation only.
module unified_mem_arbiter_checker #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            rst_n,
  input logic            if_done,
  input logic            dm_done,
  input logic            err,
  input logic            mem_req,
  input logic            mem_we,
  input logic [DW/8-1:0] mem_wstrb,
  input logic [AW-1:0]   mem_addr
);

  // only one side can finish in any cycle
  a_one_done: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_done && dm_done));

  // an abort always completes the owner's access
  a_err_done: assert property (@(posedge clk) disable iff (!rst_n)
    err |-> (if_done || dm_done));

  // the memory only ever sees word addresses
  a_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    mem_req |-> (mem_addr[1:0] == 2'b00));

  // loads never carry byte enables
  a_load_strb: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_we) |-> (mem_wstrb == {(DW/8){1'b0}}));

endmodule

module unified_mem_arbiter #(
  parameter int            AW            = 32,
  parameter int            DW            = 32,
  parameter int            TIMEOUT       = 16,
  parameter int            MAX_DM_STREAK = 4,
  parameter logic [DW-1:0] NOP_INSTR     = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch side
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  // data side
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_wstrb,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_stall,
  // status
  output logic            err,
  // unified memory
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int SB = DW / 8;
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ABORT  = 2'd3;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);

  // Drop the byte offset; the memory is addressed by whole words.
  function automatic logic [AW-1:0] word_align(input logic [AW-1:0] a);
    return a & {{(AW-2){1'b1}}, 2'b00};
  endfunction

  logic [1:0]    state_r;
  logic          owner_dm_r;
  logic [SW-1:0] streak_r;
  logic [TW-1:0] tmo_r;

  logic          mem_req_r;
  logic          mem_we_r;
  logic [SB-1:0] mem_wstrb_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  logic          if_done_r;
  logic          dm_done_r;
  logic          err_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] dm_rdata_r;

  logic          grant_s;
  logic          grant_dm_s;
  logic [SW-1:0] streak_nxt_s;
  logic [AW-1:0] sel_addr_s;

  // Grant decision: data wins a conflict until it has won MAX_DM_STREAK
  // times in a row over a waiting fetch, then the fetch goes once.
  always_comb begin
    grant_s      = 1'b0;
    grant_dm_s   = 1'b0;
    streak_nxt_s = streak_r;
    if (dm_req && if_req) begin
      grant_s = 1'b1;
      if (streak_r == STREAK_MAX) begin
        grant_dm_s   = 1'b0;
        streak_nxt_s = {SW{1'b0}};
      end else begin
        grant_dm_s   = 1'b1;
        streak_nxt_s = streak_r + STREAK_ONE;
      end
    end else if (dm_req) begin
      grant_s      = 1'b1;
      grant_dm_s   = 1'b1;
      streak_nxt_s = {SW{1'b0}};
    end else if (if_req) begin
      grant_s      = 1'b1;
      grant_dm_s   = 1'b0;
      streak_nxt_s = {SW{1'b0}};
    end else begin
      grant_s      = 1'b0;
      grant_dm_s   = 1'b0;
      streak_nxt_s = {SW{1'b0}};
    end
  end

  // Address of the side about to be granted.
  always_comb begin
    if (grant_dm_s) begin
      sel_addr_s = word_align(dm_addr);
    end else begin
      sel_addr_s = word_align(if_addr);
    end
  end

  // Arbiter FSM: latch the granted request, run one memory access,
  // then report completion or abort to the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      owner_dm_r  <= 1'b0;
      streak_r    <= {SW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wstrb_r <= {SB{1'b0}};
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      if_done_r   <= 1'b0;
      dm_done_r   <= 1'b0;
      err_r       <= 1'b0;
      if_rdata_r  <= NOP_INSTR;
      dm_rdata_r  <= {DW{1'b0}};
    end else begin
      // completion strobes are single-cycle unless re-armed below
      if_done_r <= 1'b0;
      dm_done_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          streak_r <= streak_nxt_s;
          if (grant_s) begin
            state_r    <= ST_ACCESS;
            owner_dm_r <= grant_dm_s;
            tmo_r      <= {TW{1'b0}};
            mem_req_r  <= 1'b1;
            mem_addr_r <= sel_addr_s;
            if (grant_dm_s) begin
              mem_we_r    <= dm_we;
              mem_wstrb_r <= dm_we ? dm_wstrb : {SB{1'b0}};
              mem_wdata_r <= dm_wdata;
            end else begin
              mem_we_r    <= 1'b0;
              mem_wstrb_r <= {SB{1'b0}};
              mem_wdata_r <= {DW{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          tmo_r <= tmo_r + TMO_ONE;
          if (mem_ready) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_DONE;
            if (owner_dm_r) begin
              dm_done_r <= 1'b1;
              // stores leave the load register untouched
              if (!mem_we_r) begin
                dm_rdata_r <= mem_rdata;
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else begin
              if_done_r  <= 1'b1;
              if_rdata_r <= mem_rdata;
            end
          end else if (tmo_r == TMO_LAST) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_ABORT;
            err_r     <= 1'b1;
            if (owner_dm_r) begin
              dm_done_r <= 1'b1;
              if (!mem_we_r) begin
                dm_rdata_r <= {DW{1'b0}};
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else begin
              // an aborted fetch hands the pipeline a harmless instruction
              if_done_r  <= 1'b1;
              if_rdata_r <= NOP_INSTR;
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        // the done/err strobes were armed on entry; these states only
        // spend the one cycle that keeps the arbiter from re-granting
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_ABORT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_done   = if_done_r;
  assign dm_done   = dm_done_r;
  assign err       = err_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;

  // stall drops in the same cycle the done pulse is presented
  assign if_stall  = if_req & ~if_done_r;
  assign dm_stall  = dm_req & ~dm_done_r;

  unified_mem_arbiter_checker #(
    .AW (AW),
    .DW (DW)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_done   (if_done_r),
    .dm_done   (dm_done_r),
    .err       (err_r),
    .mem_req   (mem_req_r),
    .mem_we    (mem_we_r),
    .mem_wstrb (mem_wstrb_r),
    .mem_addr  (mem_addr_r)
  );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed checks of reset, single fetch,
// conflict ordering, streak limit, timeout and reset mid-access, then a
// randomized phase scored against a behavioural memory and shadow model.
module tb_unified_mem_arbiter;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          TIMEOUT = 16;
  localparam int          MAXS    = 4;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam int          NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, if_done, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_stall;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        err;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW (AW), .DW (DW), .TIMEOUT (TIMEOUT), .MAX_DM_STREAK (MAXS),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .if_req (if_req), .if_addr (if_addr), .if_done (if_done),
    .if_rdata (if_rdata), .if_stall (if_stall),
    .dm_req (dm_req), .dm_we (dm_we), .dm_wstrb (dm_wstrb),
    .dm_addr (dm_addr), .dm_wdata (dm_wdata), .dm_done (dm_done),
    .dm_rdata (dm_rdata), .dm_stall (dm_stall),
    .err (err),
    .mem_req (mem_req), .mem_we (mem_we), .mem_wstrb (mem_wstrb),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .mem_ready (mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // contents of a never-written memory word
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------- random-phase models ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        if_exp_q[$];
  exp_t        dm_exp_q[$];
  int          if_lat_q[$];
  int          dm_lat_q[$];
  logic [31:0] shadow[logic [31:0]];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] last_dm_rdata;
  bit          rand_done;

  task automatic if_driver();
    int          idle, lat;
    logic [31:0] a;
    exp_t        e;
    bit          seen;
    for (int n = 0; n < 40; n++) begin
      idle = $urandom_range(1, 3);
      repeat (idle) begin @(posedge clk); #2; end
      a = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      e.err  = (lat == NEVER);
      e.data = e.err ? NOP : init_word({a[31:2], 2'b00});
      if_lat_q.push_back(lat);
      if_exp_q.push_back(e);
      if_req  = 1'b1;
      if_addr = a;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(posedge clk); #2;
        if (if_done) seen = 1'b1;
      end
      chk1("if_wait_done", seen, 1'b1);
      if_req = 1'b0;
    end
  endtask

  task automatic dm_driver();
    int          idle, lat;
    logic [31:0] a, wa, wd, old;
    logic [3:0]  st;
    logic        we;
    exp_t        e;
    bit          seen;
    for (int n = 0; n < 40; n++) begin
      idle = $urandom_range(1, 3);
      repeat (idle) begin @(posedge clk); #2; end
      we = 1'($urandom_range(0, 1));
      a  = 32'h2000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      wa = {a[31:2], 2'b00};
      st = 4'($urandom_range(1, 15));
      wd = $urandom;
      lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
      e.err = (lat == NEVER);
      old = shadow.exists(wa) ? shadow[wa] : init_word(wa);
      if (we) begin
        e.data = last_dm_rdata;
        if (!e.err) shadow[wa] = merge(old, wd, st);
      end else begin
        e.data = e.err ? 32'h0 : old;
        last_dm_rdata = e.data;
      end
      dm_lat_q.push_back(lat);
      dm_exp_q.push_back(e);
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = wd;
      dm_wstrb = we ? st : 4'($urandom_range(0, 15));
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(posedge clk); #2;
        if (dm_done) seen = 1'b1;
      end
      chk1("dm_wait_done", seen, 1'b1);
      dm_req = 1'b0;
    end
  endtask

  // behavioural memory: answers each access after its planned wait
  task automatic mem_model();
    bit          busy = 1'b0;
    int          cnt = 0, plan = 0, hi = 0, run = 0;
    logic [31:0] old;
    while (!rand_done) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (busy && !mem_req) begin
        chki("mem_req_cycles", hi, (plan == NEVER) ? TIMEOUT : plan + 1);
        busy = 1'b0;
      end
      if (mem_req && !busy) begin
        busy = 1'b1;
        hi = 0;
        chki("mem_addr_aligned", int'(mem_addr[1:0]), 0);
        if (mem_addr[13:12] == 2'd1) begin
          run = 0;
          chk1("if_access_we", mem_we, 1'b0);
          chk1("if_plan_avail", if_lat_q.size() > 0, 1'b1);
          plan = (if_lat_q.size() > 0) ? if_lat_q.pop_front() : 0;
        end else begin
          // if_req here still holds its value from the grant cycle
          if (if_req) run++;
          else run = 0;
          chk1("dm_streak_bound", run <= MAXS, 1'b1);
          if (!mem_we) chk("load_wstrb", {28'h0, mem_wstrb}, 32'h0);
          chk1("dm_plan_avail", dm_lat_q.size() > 0, 1'b1);
          plan = (dm_lat_q.size() > 0) ? dm_lat_q.pop_front() : 0;
        end
        cnt = plan;
      end
      if (busy && mem_req) begin
        hi++;
        if (cnt == 0) begin
          mem_ready = 1'b1;
          old = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
          if (mem_we) mem_arr[mem_addr] = merge(old, mem_wdata, mem_wstrb);
          else mem_rdata = old;
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  endtask

  // scoreboard monitor: compares every done pulse with the queued result
  task automatic monitor();
    exp_t e;
    while (!rand_done) begin
      @(posedge clk); #1;
      if (if_done || dm_done || err) begin
        chk1("single_done", if_done && dm_done, 1'b0);
        chk1("err_has_done", err && !(if_done || dm_done), 1'b0);
      end
      if (if_done) begin
        chk1("if_exp_avail", if_exp_q.size() > 0, 1'b1);
        if (if_exp_q.size() > 0) begin
          e = if_exp_q.pop_front();
          chk("if_rdata", if_rdata, e.data);
          chk1("if_err", err, e.err);
        end
      end
      if (dm_done) begin
        chk1("dm_exp_avail", dm_exp_q.size() > 0, 1'b1);
        if (dm_exp_q.size() > 0) begin
          e = dm_exp_q.pop_front();
          chk("dm_rdata", dm_rdata, e.data);
          chk1("dm_err", err, e.err);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dmg, cnt;
    bit got_if, ended, seen;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0; rand_done = 1'b0; last_dm_rdata = 32'h0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_req_held", mem_req, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_if_rdata", if_rdata, NOP);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_dm_done", dm_done, 1'b0);
    chk1("rst_err", err, 1'b0);

    // ---- single fetch ----
    if_req = 1'b1; if_addr = 32'h104;
    #1 chk1("fetch_stall_c0", if_stall, 1'b1);
    step();
    chk1("fetch_mem_req_c1", mem_req, 1'b1);
    chk("fetch_mem_addr", mem_addr, 32'h104);
    chk1("fetch_mem_we", mem_we, 1'b0);
    chk1("fetch_stall_c1", if_stall, 1'b1);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    #1 chk1("fetch_stall_c2", if_stall, 1'b1);
    chk1("fetch_done_c2", if_done, 1'b0);
    step();
    chk1("fetch_done_c3", if_done, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    chk1("fetch_mem_req_c3", mem_req, 1'b0);
    chk1("fetch_stall_c3", if_stall, 1'b0);
    mem_ready = 1'b0; if_req = 1'b0;
    step();
    chk1("fetch_done_c4", if_done, 1'b0);

    // ---- simultaneous store + fetch ----
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2003; dm_wstrb = 4'hF; dm_wdata = 32'hDEADBEEF;
    step();
    chk1("sim_mem_req", mem_req, 1'b1);
    chk("sim_dm_addr", mem_addr, 32'h2000);
    chk1("sim_dm_we", mem_we, 1'b1);
    chk("sim_dm_wstrb", {28'h0, mem_wstrb}, 32'hF);
    chk("sim_dm_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    chk1("sim_dm_done", dm_done, 1'b1);
    chk1("sim_if_not_done", if_done, 1'b0);
    chk("sim_dm_rdata_kept", dm_rdata, 32'h0);
    mem_ready = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();
    chk1("sim_idle_gap", mem_req, 1'b0);
    step();
    chk1("sim_if_mem_req", mem_req, 1'b1);
    chk("sim_if_addr", mem_addr, 32'h200);
    chk1("sim_if_we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    step();
    chk1("sim_if_done", if_done, 1'b1);
    chk("sim_if_rdata", if_rdata, 32'h11111111);
    mem_ready = 1'b0; if_req = 1'b0;
    step();

    // ---- streak limit ----
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2040; mem_rdata = 32'h22222222;
    dmg = 0; got_if = 1'b0;
    for (int c = 0; c < 60 && !got_if; c++) begin
      step();
      mem_ready = 1'b0;
      if (mem_req) begin
        if (mem_addr == 32'h300) got_if = 1'b1;
        else begin dmg++; mem_ready = 1'b1; end
      end
    end
    chk1("streak_if_granted", got_if, 1'b1);
    chki("streak_dm_grants", dmg, MAXS);
    dm_req = 1'b0; mem_ready = 1'b1;
    step();
    chk1("streak_if_done", if_done, 1'b1);
    chk("streak_if_rdata", if_rdata, 32'h22222222);
    mem_ready = 1'b0; if_req = 1'b0;
    step();

    // ---- timeout ----
    if_req = 1'b1; if_addr = 32'h400;
    cnt = 0; ended = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      step();
      if (mem_req) cnt++;
      else if (cnt > 0) ended = 1'b1;
    end
    chk1("tmo_ended", ended, 1'b1);
    chki("tmo_cycles", cnt, TIMEOUT);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_if_done", if_done, 1'b1);
    chk("tmo_if_rdata", if_rdata, NOP);
    chk1("tmo_dm_done", dm_done, 1'b0);
    if_req = 1'b0;
    step();
    chk1("tmo_err_pulse", err, 1'b0);

    // ---- reset mid-access ----
    if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h33333333;
    step();
    chk1("rma_mem_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk1("rma_async_drop", mem_req, 1'b0);
    if_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (if_done || dm_done || err || mem_req) seen = 1'b1;
    end
    chk1("rma_no_activity", seen, 1'b0);
    chk("rma_if_rdata", if_rdata, NOP);

    // ---- randomized traffic ----
    fork
      begin
        fork
          if_driver();
          dm_driver();
        join
        repeat (5) @(posedge clk);
        rand_done = 1'b1;
      end
      mem_model();
      monitor();
    join
    chki("if_exp_left", if_exp_q.size(), 0);
    chki("dm_exp_left", dm_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
